// File: rtl/bridge_pkg.sv
// Shared definitions for the clocked-to-4-phase bundled-data bridge.
package bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    REQ_HI = 2'd2,
    ACK_HI = 2'd3
  } bridge_state_t;

  localparam logic [1:0] FIFO_DEPTH = 2'd2;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level, reset to 0.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/sync_to_4phase_bridge.sv
// Clocked valid/ready to 4-phase bundled-data bridge with a 2-entry FIFO
// and a synchronized acknowledge.
module sync_to_4phase_bridge
  import bridge_pkg::*;
#(
  parameter int unsigned wd          = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [wd-1:0] in_data,
  output logic          in_ready,
  output logic          a_req,
  output logic [wd-1:0] a_data,
  input  logic          a_ack,
  output logic          busy
);

  logic                   ack_s;
  logic [wd-1:0]          mem [FIFO_DEPTH];
  logic                   wr_ptr, rd_ptr;
  logic [1:0]             count;
  logic [SYNC_STAGES-1:0] primed;
  logic                   push, pop;
  bridge_state_t          state, state_next;

  sync_ff #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (a_ack),
    .q     (ack_s)
  );

  assign in_ready = (count < FIFO_DEPTH);
  assign push     = in_valid && in_ready;
  assign busy     = (state != IDLE) || (count != '0);

  // ack_s reads 0 straight out of reset regardless of a_ack; hold off new
  // handshakes until the synchronizer holds genuine samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) primed <= '0;
    else        primed <= {primed[SYNC_STAGES-2:0], 1'b1};
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0 && !ack_s && primed[SYNC_STAGES-1]) begin
          pop        = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP:   state_next = REQ_HI;
      REQ_HI:  if (ack_s)  state_next = ACK_HI;
      ACK_HI:  if (!ack_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_req <= 1'b0;
    end else begin
      state <= state_next;
      a_req <= (state_next == REQ_HI);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
      a_data <= '0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        a_data <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_to_4phase_bridge.sv
// Self-checking bench: behavioural queue model plus directed and random traffic.
module tb_sync_to_4phase_bridge;

  localparam int unsigned WD = 4;
  localparam int unsigned SS = 2;

  logic          clk = 1'b0;
  logic          rst_n, in_valid, in_ready, a_req, a_ack, busy;
  logic [WD-1:0] in_data, a_data;

  int unsigned total = 0, bad = 0;

  sync_to_4phase_bridge #(.wd(WD), .SYNC_STAGES(SS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .a_req    (a_req),
    .a_data   (a_data),
    .a_ack    (a_ack),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: words queue, one in flight, ack seen SS edges late.
  logic [WD-1:0] m_q[$];
  logic [WD-1:0] sb[$];
  logic [WD-1:0] hs_log[$];
  bit            ack_hist[$];
  int unsigned   m_n = 0, m_pushes = 0, hs_count = 0;
  bit            m_active = 0, m_setup = 0, m_req = 0, m_acked = 0;
  logic [WD-1:0] m_data = '0;

  initial begin : model
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_q.delete(); sb.delete(); ack_hist.delete();
        m_n = 0; m_active = 0; m_setup = 0; m_req = 0; m_acked = 0; m_data = '0;
      end else begin : edge_step
        bit ack_seen, ready_to_start, accept, start;
        ready_to_start = (m_n >= SS);
        ack_seen = ready_to_start ? ack_hist[m_n - SS] : 1'b0;
        accept   = in_valid && (m_q.size() < 2);
        start    = !m_active && (m_q.size() > 0) && !ack_seen && ready_to_start;
        if (start) begin
          m_data = m_q.pop_front();
          m_active = 1; m_setup = 1;
        end else if (m_active && m_setup) begin
          m_setup = 0; m_req = 1;
        end else if (m_req) begin
          if (ack_seen) begin m_req = 0; m_acked = 1; end
        end else if (m_acked) begin
          if (!ack_seen) begin m_acked = 0; m_active = 0; end
        end
        if (accept) begin
          m_q.push_back(in_data);
          sb.push_back(in_data);
          m_pushes++;
        end
        ack_hist.push_back(a_ack);
        m_n++;
      end
    end
  end

  // Per-cycle compare against the model, order scoreboard, data stability.
  logic          prev_req = 0, prev_ack = 0, prev_rst = 0;
  logic [WD-1:0] prev_data = '0;

  initial begin : compare
    forever begin
      @(negedge clk);
      if (rst_n && prev_rst) begin
        chk("a_req", 32'(a_req), 32'(m_req));
        chk("a_data", 32'(a_data), 32'(m_data));
        chk("in_ready", 32'(in_ready), 32'(m_q.size() < 2));
        chk("busy", 32'(busy), 32'(m_active || m_q.size() != 0));
        if (prev_req || prev_ack) chk("a_data_stable", 32'(a_data), 32'(prev_data));
        if (a_req && !prev_req) begin
          hs_count++;
          hs_log.push_back(a_data);
          if (sb.size() == 0) chk("order_unexpected_word", 32'(a_data), 32'hFFFF_FFFF);
          else                chk("order", 32'(a_data), 32'(sb.pop_front()));
        end
      end
      prev_req  = a_req;
      prev_ack  = a_ack;
      prev_data = a_data;
      prev_rst  = rst_n;
    end
  end

  // Handshake responder with random reaction delay.
  bit          resp_en = 0;
  int unsigned resp_max = 7, resp_cnt = 0;

  initial begin : responder
    forever begin
      @(posedge clk);
      #1;
      if (resp_en) begin
        if (!a_ack && a_req) begin
          if (resp_cnt == 0) begin a_ack = 1'b1; resp_cnt = $urandom_range(0, resp_max); end
          else resp_cnt--;
        end else if (a_ack && !a_req) begin
          if (resp_cnt == 0) begin a_ack = 1'b0; resp_cnt = $urandom_range(0, resp_max); end
          else resp_cnt--;
        end
      end
    end
  end

  task automatic drain(input string name);
    int unsigned c = 0;
    while ((m_active || m_q.size() != 0 || sb.size() != 0) && c < 3000) begin
      step();
      c++;
    end
    chk({name, "_timeout"}, 32'(c < 3000), 32'd1);
    chk({name, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_model_req(input bit level, input string name);
    int unsigned c = 0;
    while (m_req != level && c < 200) begin
      step();
      c++;
    end
    chk(name, 32'(c < 200), 32'd1);
  endtask

  initial begin : main
    int unsigned c, target, sent, pre, h0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; a_ack = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_req", 32'(a_req), 32'd0);
    chk("rst_a_data", 32'(a_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    #2 rst_n = 1'b1;
    repeat (3) step();

    // Single word, ack 3 cycles after a_req rises
    in_valid = 1'b1; in_data = 4'hA; step(); in_valid = 1'b0;
    chk("t1_busy_e1", 32'(busy), 32'd1);
    step();
    chk("t1_data_e2", 32'(a_data), 32'hA);
    chk("t1_req_e2", 32'(a_req), 32'd0);
    step();
    chk("t1_req_e3", 32'(a_req), 32'd1);
    repeat (3) step();
    a_ack = 1'b1;
    step(); chk("t1_req_held1", 32'(a_req), 32'd1);
    step(); chk("t1_req_held2", 32'(a_req), 32'd1);
    step(); chk("t1_req_fall", 32'(a_req), 32'd0);
    a_ack = 1'b0;
    step(); step();
    chk("t1_busy_acklo", 32'(busy), 32'd1);
    step();
    chk("t1_busy_idle", 32'(busy), 32'd0);

    // Back-pressure with a_ack held low
    in_valid = 1'b1; in_data = 4'h1; step();
    in_data = 4'h2; step();
    chk("t2_first_pop", 32'(a_data), 32'h1);
    in_data = 4'h3; step();
    chk("t2_full", 32'(in_ready), 32'd0);
    in_data = 4'h4; step();
    chk("t2_full_hold", 32'(in_ready), 32'd0);
    chk("t2_req", 32'(a_req), 32'd1);
    step();
    chk("t2_full_hold2", 32'(in_ready), 32'd0);
    target = m_pushes + 1;
    resp_max = 3; resp_en = 1;
    c = 0;
    while (m_pushes < target && c < 500) begin step(); c++; end
    chk("t2_word4_accepted", 32'(c < 500), 32'd1);
    in_valid = 1'b0;
    drain("t2_drain");
    chk("t2_order_1", 32'(hs_log[hs_log.size()-4]), 32'h1);
    chk("t2_order_2", 32'(hs_log[hs_log.size()-3]), 32'h2);
    chk("t2_order_3", 32'(hs_log[hs_log.size()-2]), 32'h3);
    chk("t2_order_4", 32'(hs_log[hs_log.size()-1]), 32'h4);

    // Simultaneous push and pop with one word buffered
    resp_en = 0;
    in_valid = 1'b1; in_data = 4'h6; step(); in_valid = 1'b0;
    step();
    in_valid = 1'b1; in_data = 4'h7; step(); in_valid = 1'b0;
    chk("t3_req", 32'(a_req), 32'd1);
    a_ack = 1'b1;
    wait_model_req(1'b0, "t3_req_fall");
    a_ack = 1'b0;
    c = 0;
    while (m_active && c < 50) begin step(); c++; end
    chk("t3_idle", 32'(c < 50), 32'd1);
    in_valid = 1'b1; in_data = 4'h5; step(); in_valid = 1'b0;
    chk("t3_pop7", 32'(a_data), 32'h7);
    chk("t3_count1", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_data = 4'h8; step(); in_valid = 1'b0;
    chk("t3_count2", 32'(in_ready), 32'd0);
    resp_en = 1;
    drain("t3_drain");
    chk("t3_order_6", 32'(hs_log[hs_log.size()-4]), 32'h6);
    chk("t3_order_7", 32'(hs_log[hs_log.size()-3]), 32'h7);
    chk("t3_order_5", 32'(hs_log[hs_log.size()-2]), 32'h5);
    chk("t3_order_8", 32'(hs_log[hs_log.size()-1]), 32'h8);

    // Reset during REQ_HI with a_ack high
    resp_en = 0;
    in_valid = 1'b1; in_data = 4'h9; step(); in_valid = 1'b0;
    wait_model_req(1'b1, "t4_reach_req");
    a_ack = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("t4_async_req", 32'(a_req), 32'd0);
    chk("t4_async_busy", 32'(busy), 32'd0);
    chk("t4_async_data", 32'(a_data), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    in_valid = 1'b1; in_data = 4'hB; step(); in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t4_hold_ack_hi", 32'(a_req), 32'd0);
    end
    a_ack = 1'b0;
    for (int i = 0; i < int'(SS) + 1; i++) begin
      step();
      chk("t4_wait_ack_lo", 32'(a_req), 32'd0);
    end
    step();
    chk("t4_start", 32'(a_req), 32'd1);
    chk("t4_word", 32'(a_data), 32'hB);
    resp_en = 1;
    drain("t4_drain");

    // Random stress
    resp_max = 7;
    sent = 0; c = 0; h0 = hs_count;
    while (sent < 1000 && c < 60000) begin
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_data  = WD'($urandom);
      end
      pre = m_pushes;
      step();
      c++;
      if (m_pushes != pre) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk("stress_sent", sent, 32'd1000);
    drain("stress_drain");
    chk("stress_sb_empty", 32'(sb.size()), 32'd0);
    chk("stress_delivered", hs_count - h0, 32'd1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
